// File: rtl/regfile_sb_pkg.sv
// Shared constants, index type and popcount helper for the regfile_sb block.
// Data width follows `XLEN (defaults to 32 when the build does not set it).
`ifndef XLEN
`define XLEN 32
`endif

package regfile_sb_pkg;
    localparam int NREG   = 32;
    localparam int IW     = 5;
    localparam int XLEN_W = `XLEN;

    typedef logic [IW-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    function automatic logic [IW:0] popcount(input logic [NREG-1:0] v);
        logic [IW:0] n;
        n = '0;
        for (int i = 0; i < NREG; i++) begin
            n = n + {{IW{1'b0}}, v[i]};
        end
        return n;
    endfunction
endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register, priority flush > set > clear,
// with a registered popcount of the pending bits updated alongside them.
module regfile_sb_scoreboard
    import regfile_sb_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            set_en_i,
    input  reg_idx_t        set_idx_i,
    input  logic            clr_en_i,
    input  reg_idx_t        clr_idx_i,
    input  logic            flush_i,
    output logic [NREG-1:0] pend_o,
    output logic [IW:0]     cnt_o
);
    logic [NREG-1:0] pend_q, pend_d;
    logic [IW:0]     cnt_q, cnt_d;

    always_comb begin
        pend_d = pend_q;
        if (clr_en_i && clr_idx_i != REG_ZERO) pend_d[clr_idx_i] = 1'b0;
        // A same-cycle set overrides the clear: the newer producer is outstanding.
        if (set_en_i && set_idx_i != REG_ZERO) pend_d[set_idx_i] = 1'b1;
        if (flush_i) pend_d = '0;
        pend_d[0] = 1'b0;
        cnt_d = popcount(pend_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend_o = pend_q;
    assign cnt_o  = cnt_q;
endmodule

// File: rtl/regfile_sb.sv
// Integer register file (x0 hardwired to zero) with two combinational read ports and a RAW scoreboard.
// Optional same-cycle writeback forwarding to the read ports: define REGFILE_WB_BYPASS_EN.
module regfile_sb #(
    parameter int DW   = `XLEN,
    parameter int NREG = 32,
    parameter int IW   = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wb_rd_en_i,
    input  logic [IW-1:0] wb_rd_idx_i,
    input  logic [DW-1:0] wb_rd_wdata_i,
    input  logic [IW-1:0] rs1_idx_i,
    input  logic [IW-1:0] rs2_idx_i,
    output logic [DW-1:0] rs1_rdata_o,
    output logic [DW-1:0] rs2_rdata_o,
    output logic          rs1_busy_o,
    output logic          rs2_busy_o,
    input  logic          iss_valid_i,
    input  logic          iss_rd_en_i,
    input  logic [IW-1:0] iss_rd_idx_i,
    input  logic          flush_i,
    output logic [IW:0]   pend_cnt_o
);
    import regfile_sb_pkg::*;

    logic [DW-1:0]   regs_q [NREG];
    logic [NREG-1:0] pend;
    logic            wb_wr;

    assign wb_wr = wb_rd_en_i && (wb_rd_idx_i != '0) && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (wb_wr) begin
            regs_q[wb_rd_idx_i] <= wb_rd_wdata_i;
        end
    end

    regfile_sb_scoreboard u_sb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .set_en_i  (iss_valid_i && iss_rd_en_i),
        .set_idx_i (iss_rd_idx_i),
        .clr_en_i  (wb_rd_en_i),
        .clr_idx_i (wb_rd_idx_i),
        .flush_i   (flush_i),
        .pend_o    (pend),
        .cnt_o     (pend_cnt_o)
    );

`ifdef REGFILE_WB_BYPASS_EN
    logic iss_set;
    assign iss_set = iss_valid_i && iss_rd_en_i && (iss_rd_idx_i != '0);
`endif

    always_comb begin
        rs1_rdata_o = (rs1_idx_i == '0) ? '0 : regs_q[rs1_idx_i];
        rs2_rdata_o = (rs2_idx_i == '0) ? '0 : regs_q[rs2_idx_i];
        rs1_busy_o  = pend[rs1_idx_i] && (rs1_idx_i != '0);
        rs2_busy_o  = pend[rs2_idx_i] && (rs2_idx_i != '0);
`ifdef REGFILE_WB_BYPASS_EN
        // Forwarded data satisfies the consumer unless an issue re-marks the register now.
        if (wb_wr && wb_rd_idx_i == rs1_idx_i) begin
            rs1_rdata_o = wb_rd_wdata_i;
            rs1_busy_o  = rs1_busy_o && iss_set && (iss_rd_idx_i == rs1_idx_i);
        end
        if (wb_wr && wb_rd_idx_i == rs2_idx_i) begin
            rs2_rdata_o = wb_rd_wdata_i;
            rs2_busy_o  = rs2_busy_o && iss_set && (iss_rd_idx_i == rs2_idx_i);
        end
`endif
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed table of cycles followed by random traffic against a reference model.
`ifndef XLEN
`define XLEN 32
`endif

module tb_regfile_sb;
    localparam int DW = `XLEN;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_en;
    logic [4:0]    wb_idx;
    logic [DW-1:0] wb_dat;
    logic [4:0]    rs1, rs2;
    logic [DW-1:0] rs1_dat, rs2_dat;
    logic          rs1_busy, rs2_busy;
    logic          iss_v, iss_en;
    logic [4:0]    iss_idx;
    logic          flush;
    logic [5:0]    cnt;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk_i(clk), .rst_i(rst),
        .wb_rd_en_i(wb_en), .wb_rd_idx_i(wb_idx), .wb_rd_wdata_i(wb_dat),
        .rs1_idx_i(rs1), .rs2_idx_i(rs2),
        .rs1_rdata_o(rs1_dat), .rs2_rdata_o(rs2_dat),
        .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy),
        .iss_valid_i(iss_v), .iss_rd_en_i(iss_en), .iss_rd_idx_i(iss_idx),
        .flush_i(flush), .pend_cnt_o(cnt)
    );

    typedef struct {
        bit            chk;
        bit            rst, wb_en, iss_v, flush;
        logic [4:0]    wb_idx, iss_idx, rs1, rs2;
        logic [DW-1:0] wb_dat, e1, e2;
        bit            b1, b2;
        int            ecnt;
    } vec_t;

    vec_t tbl[$];
    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [DW-1:0] m_regs [32];
    bit            m_pend [32];

    task automatic row(bit chk, bit r, bit we, int wi, logic [DW-1:0] wd, bit iv, int ii, bit fl,
                       int a, int b, logic [DW-1:0] e1, logic [DW-1:0] e2, bit b1, bit b2, int ec);
        vec_t v;
        v.chk = chk; v.rst = r; v.wb_en = we; v.wb_idx = 5'(wi); v.wb_dat = wd;
        v.iss_v = iv; v.iss_idx = 5'(ii); v.flush = fl; v.rs1 = 5'(a); v.rs2 = 5'(b);
        v.e1 = e1; v.e2 = e2; v.b1 = b1; v.b2 = b2; v.ecnt = ec;
        tbl.push_back(v);
    endtask

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit hit(logic [4:0] idx);
        return BYP && wb_en && !rst && wb_idx == idx && idx != 0;
    endfunction

    function automatic logic [DW-1:0] m_data(logic [4:0] idx);
        if (idx == 0) return '0;
        if (hit(idx)) return wb_dat;
        return m_regs[idx];
    endfunction

    function automatic bit m_busy(logic [4:0] idx);
        bit b;
        b = (idx != 0) && m_pend[idx];
        if (hit(idx) && !(iss_v && iss_en && iss_idx == idx)) b = 1'b0;
        return b;
    endfunction

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    task automatic model_step();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_pend[i] = 1'b0; end
        end else begin
            if (wb_en && wb_idx != 0) begin
                m_regs[wb_idx] = wb_dat;
                m_pend[wb_idx] = 1'b0;
            end
            if (iss_v && iss_en && iss_idx != 0) m_pend[iss_idx] = 1'b1;
            if (flush) for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        end
    endtask

    initial begin
        rst = 1; wb_en = 0; wb_idx = 0; wb_dat = '0; rs1 = 0; rs2 = 0;
        iss_v = 0; iss_en = 0; iss_idx = 0; flush = 0;
        for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_pend[i] = 1'b0; end

        //   chk rst we wi wdata         iv ii fl rs1 rs2 e1            e2  b1 b2 cnt
        row(0, 1, 0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 0, 0, 0);
        row(1, 0, 0, 0, 0,            0, 0, 0, 5, 0, 0,            0, 0, 0, 0);
        row(1, 0, 1, 3, 'hDEADBEEF,   0, 0, 0, 3, 0, BYP ? 'hDEADBEEF : 0, 0, 0, 0, 0);
        row(1, 0, 1, 0, 'h1234,       0, 0, 0, 3, 0, 'hDEADBEEF,  0, 0, 0, 0);
        row(1, 0, 0, 0, 0,            1, 7, 0, 7, 0, 0,            0, 0, 0, 0);
        row(1, 0, 0, 0, 0,            0, 0, 0, 7, 0, 0,            0, 1, 0, 1);
        row(1, 0, 1, 7, 'h55,         0, 0, 0, 7, 0, BYP ? 'h55 : 0, 0, !BYP, 0, 1);
        row(1, 0, 0, 0, 0,            0, 0, 0, 7, 0, 'h55,         0, 0, 0, 0);
        row(1, 0, 0, 0, 0,            1, 9, 0, 9, 0, 0,            0, 0, 0, 0);
        row(1, 0, 1, 9, 'hAA,         1, 9, 0, 9, 0, BYP ? 'hAA : 0, 0, 1, 0, 1);
        row(1, 0, 0, 0, 0,            0, 0, 0, 9, 0, 'hAA,         0, 1, 0, 1);
        row(1, 0, 1, 9, 'hAB,         0, 0, 0, 9, 9, BYP ? 'hAB : 'hAA, BYP ? 'hAB : 'hAA, !BYP, !BYP, 1);
        row(1, 0, 0, 0, 0,            0, 0, 0, 9, 0, 'hAB,         0, 0, 0, 0);
        row(1, 0, 0, 0, 0,            1, 1, 0, 1, 2, 0,            0, 0, 0, 0);
        row(1, 0, 0, 0, 0,            1, 2, 0, 1, 2, 0,            0, 1, 0, 1);
        row(1, 0, 0, 0, 0,            1, 4, 0, 2, 4, 0,            0, 1, 0, 2);
        row(1, 0, 0, 0, 0,            1, 6, 1, 4, 1, 0,            0, 1, 1, 3);
        row(1, 0, 0, 0, 0,            0, 0, 0, 6, 4, 0,            0, 0, 0, 0);
        row(1, 0, 1, 2, 'h99,         1, 2, 0, 2, 0, BYP ? 'h99 : 0, 0, 0, 0, 0);
        row(1, 0, 0, 0, 0,            0, 0, 0, 2, 3, 'h99,  'hDEADBEEF, 1, 0, 1);
        row(1, 1, 0, 0, 0,            0, 0, 0, 2, 3, 'h99,  'hDEADBEEF, 1, 0, 1);
        row(1, 0, 0, 0, 0,            0, 0, 0, 2, 3, 0,            0, 0, 0, 0);

        @(posedge clk); #1;
        foreach (tbl[k]) begin
            rst = tbl[k].rst; wb_en = tbl[k].wb_en; wb_idx = tbl[k].wb_idx; wb_dat = tbl[k].wb_dat;
            iss_v = tbl[k].iss_v; iss_en = tbl[k].iss_v; iss_idx = tbl[k].iss_idx;
            flush = tbl[k].flush; rs1 = tbl[k].rs1; rs2 = tbl[k].rs2;
            @(negedge clk);
            if (tbl[k].chk) begin
                check($sformatf("row%0d rs1_rdata", k), 64'(rs1_dat), 64'(tbl[k].e1));
                check($sformatf("row%0d rs2_rdata", k), 64'(rs2_dat), 64'(tbl[k].e2));
                check($sformatf("row%0d rs1_busy", k), 64'(rs1_busy), 64'(tbl[k].b1));
                check($sformatf("row%0d rs2_busy", k), 64'(rs2_busy), 64'(tbl[k].b2));
                check($sformatf("row%0d pend_cnt", k), 64'(cnt), 64'(tbl[k].ecnt));
            end
            @(posedge clk);
            model_step();
            #1;
        end

        for (int c = 0; c < 600; c++) begin
            rst    = ($urandom_range(0, 63) == 0);
            wb_en  = ($urandom_range(0, 2) != 0);
            wb_idx = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wb_dat = DW'($urandom());
            iss_v  = ($urandom_range(0, 1) == 1);
            iss_en = ($urandom_range(0, 3) != 0);
            iss_idx = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            flush  = ($urandom_range(0, 15) == 0);
            rs1    = 5'($urandom_range(0, 7));
            rs2    = ($urandom_range(0, 1) == 1) ? wb_idx : 5'($urandom_range(0, 31));
            @(negedge clk);
            check($sformatf("rnd%0d rs1_rdata", c), 64'(rs1_dat), 64'(m_data(rs1)));
            check($sformatf("rnd%0d rs2_rdata", c), 64'(rs2_dat), 64'(m_data(rs2)));
            check($sformatf("rnd%0d rs1_busy", c), 64'(rs1_busy), 64'(m_busy(rs1)));
            check($sformatf("rnd%0d rs2_busy", c), 64'(rs2_busy), 64'(m_busy(rs2)));
            check($sformatf("rnd%0d pend_cnt", c), 64'(cnt), 64'(m_cnt()));
            @(posedge clk);
            model_step();
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Integer register file that is the receiving end of the writeback interface.
- Accepts the writeback stage's rd enable / index / data and stores 32 x XLEN registers.
- Serves two combinational read ports to decode.
- Tracks in-flight destination registers in a pending-write scoreboard so decode can detect RAW hazards against instructions that have not yet written back.

Parameters:
- DW, `XLEN, register data width.
- NREG, 32, number of architectural registers; x0 is hardwired to zero.
- IW, 5, register index width (log2 NREG).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- wb_rd_en_i  in  1  writeback write enable.
- wb_rd_idx_i  in  IW  writeback destination index.
- wb_rd_wdata_i  in  DW  writeback data.
- rs1_idx_i  in  IW  read port 1 index.
- rs2_idx_i  in  IW  read port 2 index.
- rs1_rdata_o  out  DW  read port 1 data.
- rs2_rdata_o  out  DW  read port 2 data.
- rs1_busy_o  out  1  rs1 has an outstanding producer.
- rs2_busy_o  out  1  rs2 has an outstanding producer.
- iss_valid_i  in  1  an instruction issues this cycle.
- iss_rd_en_i  in  1  the issuing instruction writes rd.
- iss_rd_idx_i  in  IW  rd of the issuing instruction.
- flush_i  in  1  pipeline flush; discards all pending marks.
- pend_cnt_o  out  IW+1  number of registers currently pending.

Behaviour:
- Interface: one clock (clk_i); reset (rst_i) is synchronous and active-high.
- Reset state:
  - All registers are 0 and all pending bits are 0.
  - pend_cnt_o = 0, rs*_busy_o = 0, rs*_rdata_o = 0 for any index.
  - A write or issue in the reset cycle is ignored.
- Write:
  - On the rising edge, if wb_rd_en_i && wb_rd_idx_i != 0, then reg[wb_rd_idx_i] <= wb_rd_wdata_i.
  - Writes to x0 are dropped.
- Read:
  - Combinational, zero-latency.
  - Index 0 always returns 0.
  - Otherwise returns the stored value (see the optional feature for same-cycle bypass).
- Scoreboard: one pending bit per register; bit 0 is never set.
  - Set when iss_valid_i && iss_rd_en_i && iss_rd_idx_i != 0.
  - Cleared when wb_rd_en_i && wb_rd_idx_i != 0.
  - Set and clear on the same index in the same cycle: set wins, because the newer producer is now outstanding.
  - Set on an already-pending register: the bit stays 1. There is a single outstanding producer per register; decode stalls WAW before issue.
  - Clear on a register that is not pending: no effect, no error.
  - flush_i: all pending bits go to 0 next cycle. flush_i beats a same-cycle set. The register write in that cycle still happens.
- Busy:
  - rsN_busy_o = pending[rsN_idx_i] && rsN_idx_i != 0, qualified by bypass (see the optional feature).
- Counter:
  - pend_cnt_o is a registered popcount of pending bits, updated with the bits.
  - Range 0..31; it never wraps because bit 0 is excluded.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - A same-cycle writeback to a matching nonzero index is forwarded: rsN_rdata_o = wb_rd_wdata_i.
  - rsN_busy_o is deasserted in that same cycle, unless a same-cycle issue re-marks that register.
- Undefined:
  - Reads return the stored value only.
  - Busy stays asserted through the writeback cycle and drops the following cycle. This adds one stall cycle per RAW dependency.

Decomposition:
- Shared package:
  - Constants NREG = 32, IW = 5, REG_ZERO = 5'd0.
  - Index typedef reg_idx_t.
  - Data width taken from `XLEN.
- One sub-module: regfile_sb_scoreboard.
  - Holds the pending bit vector, set/clear/flush priority, and the popcount counter.
  - Outputs the raw pending vector.
  - regfile_sb keeps the storage array, read muxes and bypass.

Test Plan:
1. Reset, then read rs1 = 5, rs2 = 0 -> both data 0, both busy 0, pend_cnt_o = 0.
2. wb write x3 = 0xDEADBEEF, then read rs1 = 3 next cycle -> 0xDEADBEEF; a write to x0 = 0x1234 then reading x0 -> 0.
3. Issue rd = 7; next cycle rs1 = 7 -> busy 1, pend_cnt_o = 1. Writeback x7 = 0x55:
   - with the macro defined: in the same cycle busy 0 and data 0x55;
   - without the macro: busy 1 in that cycle, then 0 with data 0x55 the next cycle.
4. Same cycle: issue rd = 9 and writeback x9 -> pending[9] stays 1, busy 1 next cycle, pend_cnt_o unchanged.
5. Issue rd = 1, 2, 4 over three cycles (pend_cnt_o = 3). Then flush_i together with an issue of rd = 6 -> pend_cnt_o = 0 and all busy 0 next cycle.
6. Assert rst_i while x2 is pending and x2 holds 0x99 -> next cycle x2 reads 0, busy 0, pend_cnt_o = 0.
